// File: rtl/crossy_pkg.sv
// Shared PS/2 constants, frame FSM state type and parity helper for the keyboard receiver.
package crossy_pkg;

  // Scan-code prefixes
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Set-2 scan codes used by the game controls (arrows are extended codes)
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // True when the data bits plus the parity bit hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronisers, PS2_CLK glitch filter, falling-edge
// strobe, 11-bit frame FSM with parity/stop checking and inter-edge timeout.
module ps2_frame_rx
  import crossy_pkg::*;
#(
  parameter int FILT_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic                clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic [FILT_LEN-1:0] filt_q, filt_d;
  logic                clk_f_q, clk_f_d;
  logic                strobe_s;
  ps2_state_e          state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_q, par_d;
  logic [CNT_W-1:0]    tmo_q, tmo_d;
  logic                byte_done_q, byte_done_d;
  logic                err_q, err_d;

  // Filter shift and filtered-level hysteresis; strobe on the filtered 1->0 edge
  always_comb begin
    filt_d  = {filt_q[FILT_LEN-2:0], clk_sync_q};
    clk_f_d = clk_f_q;
    if (filt_q == {FILT_LEN{1'b0}}) begin
      clk_f_d = 1'b0;
    end else if (filt_q == {FILT_LEN{1'b1}}) begin
      clk_f_d = 1'b1;
    end else begin
      clk_f_d = clk_f_q;
    end
    strobe_s = clk_f_q & ~clk_f_d;
  end

  // Synchronisers and filter state; idle-high lines reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_q     <= {FILT_LEN{1'b1}};
      clk_f_q    <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
      filt_q     <= filt_d;
      clk_f_q    <= clk_f_d;
    end
  end

  // Frame FSM next state, bit capture, frame checks and timeout abort
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    byte_done_d = 1'b0;
    err_d       = 1'b0;
    if (state_q == ST_IDLE || strobe_s) begin
      tmo_d = {CNT_W{1'b0}};
    end else begin
      tmo_d = tmo_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    case (state_q)
      ST_IDLE: begin
        if (strobe_s && !dat_sync_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (strobe_s) begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = (bit_cnt_q == 3'd7) ? ST_PARITY : ST_DATA;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (strobe_s) begin
          par_d   = dat_sync_q;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (strobe_s) begin
          if (dat_sync_q && odd_parity_ok(shift_q, par_q)) begin
            byte_done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A stalled keyboard clock mid-frame abandons the frame
    if (state_q != ST_IDLE && !strobe_s && tmo_q == TMO_LAST) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      tmo_d   = {CNT_W{1'b0}};
    end else begin
      tmo_d = tmo_d;
    end
  end

  // Frame FSM, datapath and pulse output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      tmo_q       <= {CNT_W{1'b0}};
      byte_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      byte_done_q <= byte_done_d;
      err_q       <= err_d;
    end
  end

  assign rx_byte   = shift_q;
  assign byte_done = byte_done_q;
  assign frame_err = err_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver top: frame receiver plus E0/F0 prefix decoding and
// held-level key outputs for the arrow keys and space bar.
module ps2_keyboard_rx
  import crossy_pkg::*;
#(
  parameter int FILT_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       scan_break,
  output logic       scan_ext,
  output logic       frame_err,
  output logic       key_up,
  output logic       key_down,
  output logic       key_left,
  output logic       key_right,
  output logic       key_center
);

  logic [7:0] rx_byte_s;
  logic       byte_done_s;
  logic       frame_err_s;

  logic       ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic       valid_q, valid_d, brk_q, brk_d, ext_q, ext_d;
  logic [7:0] code_q, code_d;
  logic       up_q, up_d, down_q, down_d, left_q, left_d;
  logic       right_q, right_d, center_q, center_d;
  logic       make_s;

  ps2_frame_rx #(
    .FILT_LEN       (FILT_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame (
    .clk       (CLK100MHZ),
    .rst_n     (CPU_RESETN),
    .ps2_clk   (PS2_CLK),
    .ps2_data  (PS2_DATA),
    .rx_byte   (rx_byte_s),
    .byte_done (byte_done_s),
    .frame_err (frame_err_s)
  );

  // Prefix tracking, scan report and key-level update on each received byte
  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    valid_d    = 1'b0;
    code_d     = code_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    up_d       = up_q;
    down_d     = down_q;
    left_d     = left_q;
    right_d    = right_q;
    center_d   = center_q;
    make_s     = ~brk_pend_q;
    if (frame_err_s) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (byte_done_s) begin
      if (rx_byte_s == PS2_PREFIX_EXT) begin
        ext_pend_d = 1'b1;
      end else if (rx_byte_s == PS2_PREFIX_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        valid_d    = 1'b1;
        code_d     = rx_byte_s;
        brk_d      = brk_pend_q;
        ext_d      = ext_pend_q;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
        if (ext_pend_q) begin
          case (rx_byte_s)
            SC_UP:    up_d    = make_s;
            SC_DOWN:  down_d  = make_s;
            SC_LEFT:  left_d  = make_s;
            SC_RIGHT: right_d = make_s;
            default:  up_d    = up_q;
          endcase
        end else if (rx_byte_s == SC_SPACE) begin
          center_d = make_s;
        end else begin
          center_d = center_q;
        end
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // Decode-layer registers; all outputs come straight from flops
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      valid_q    <= 1'b0;
      code_q     <= 8'h00;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      center_q   <= 1'b0;
    end else begin
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      up_q       <= up_d;
      down_q     <= down_d;
      left_q     <= left_d;
      right_q    <= right_d;
      center_q   <= center_d;
    end
  end

  assign scan_code  = code_q;
  assign scan_valid = valid_q;
  assign scan_break = brk_q;
  assign scan_ext   = ext_q;
  assign frame_err  = frame_err_s;
  assign key_up     = up_q;
  assign key_down   = down_q;
  assign key_left   = left_q;
  assign key_right  = right_q;
  assign key_center = center_q;

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
Receives PS/2 keyboard frames from the board's PS/2 host pins and decodes make/break/extended scan codes. Drives held-level arrow and centre key outputs that can feed crossy_game's btnU/D/L/R/C inputs as an alternative to the push-buttons. Sits at the top level beside the VGA and seven-segment drivers and runs on the 100 MHz board clock.

Parameters:
FILT_LEN, 8, PS2_CLK glitch-filter length in clocks; the filtered level changes only after FILT_LEN identical consecutive samples.
TIMEOUT_CYCLES, 200000, maximum gap between PS2_CLK falling edges inside a frame (2 ms at 100 MHz).

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
CPU_RESETN  in  1  asynchronous active-low reset
PS2_CLK  in  1  keyboard clock, asynchronous, idle high
PS2_DATA  in  1  keyboard data, asynchronous, idle high
scan_code  out  8  last non-prefix byte received
scan_valid  out  1  one-cycle pulse; scan_code/scan_break/scan_ext are valid in this cycle
scan_break  out  1  byte was preceded by 0xF0
scan_ext  out  1  byte was preceded by 0xE0
frame_err  out  1  one-cycle pulse on parity, stop-bit or timeout error
key_up, key_down, key_left, key_right, key_center  out  1 each  held key levels

Behaviour:
- Reset is asynchronous and active-low: one clock, CPU_RESETN. While CPU_RESETN is low, every output is 0, the FSM is in IDLE, prefixes are cleared, and synchroniser and filter state is 1.
- Both input pins pass through 2-FF synchronisers.
- The PS2_CLK filter is a FILT_LEN-bit shift register. The filtered clock goes to 0 when the register is all zeros and to 1 when it is all ones; otherwise it holds its value.
- A one-cycle strobe fires on each 1->0 transition of the filtered clock. PS2_DATA is sampled in the strobe cycle.
- Frame FSM (11-bit frame, LSB first):
  - IDLE: on a strobe with data=0, go to DATA and set bit count to 0. A strobe with data=1 is ignored.
  - DATA: shift one bit in per strobe. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit and go to STOP.
  - STOP: on a strobe, the frame is good if the stop bit is 1 and the 8 data bits plus the parity bit contain an odd number of ones. A good frame raises the internal byte_done for one cycle; a bad frame pulses frame_err. Either way, return to IDLE.
- Timeout counter: reset on every strobe and held at 0 in IDLE. If it reaches TIMEOUT_CYCLES-1 outside IDLE, the FSM returns to IDLE and frame_err pulses.
- Decode layer, acting on byte_done in cycle N:
  - 0xE0 sets ext_pend. 0xF0 sets brk_pend. Neither produces a scan_valid pulse.
  - Any other byte: in cycle N+1, scan_valid=1, scan_code=byte, scan_break=brk_pend, scan_ext=ext_pend. Both prefixes are cleared.
  - scan_code, scan_break and scan_ext hold their values until the next scan_valid.
  - Prefix order E0,F0 or F0,E0 are both accepted.
  - Any frame_err clears both prefixes and leaves key levels unchanged.
- Key map, updated in the same cycle scan_valid rises (visible at N+1). A make code sets the level, a break code clears it.
  - ext 0x75 -> key_up; ext 0x72 -> key_down; ext 0x6B -> key_left; ext 0x74 -> key_right; non-ext 0x29 (space) -> key_center.
  - Other codes, including 0xAA (BAT) and 0xFA, produce scan_valid only.
  - A repeated make (typematic) keeps the level at 1. A break for a key that is not held is harmless.
  - Multiple keys may be held simultaneously.
- The host never drives PS2_CLK or PS2_DATA; the block is receive-only.

Decomposition:
- Shared package crossy_pkg holds the constants PS2_PREFIX_EXT=0xE0, PS2_PREFIX_BRK=0xF0, and SC_UP/SC_DOWN/SC_LEFT/SC_RIGHT/SC_SPACE.
- Sub-module ps2_frame_rx contains the synchronisers, filter, strobe, frame FSM and timeout. Its outputs are byte, byte_done and frame_err.
- ps2_keyboard_rx instantiates ps2_frame_rx and implements the prefix and key-map layer.

Test Plan:
- Bit-bang 0x29 at a 10 kHz PS/2 clock, correct odd parity -> one scan_valid pulse with code 0x29, break 0, ext 0, and key_center=1. Then send F0,29 -> scan_valid with code 0x29, break 1, and key_center=0.
- Send E0,75 then E0,6B -> key_up=1 and key_left=1 together, with scan_ext=1 on both pulses. Then send E0,F0,75 -> key_up=0 and key_left stays 1.
- Send 0x1C with an even parity bit -> frame_err pulses for 1 cycle, no scan_valid, keys unchanged. Send 0x1C with stop bit 0 -> frame_err.
- Send a start bit plus 3 data bits, then stop clocking for 2.5 ms -> frame_err 200000 cycles after the last strobe. A following clean 0x29 is decoded correctly.
- Send F0, then a corrupted frame, then 0x29 -> scan_break=0 (prefix cleared by the error) and key_center=1. A 3-cycle low glitch on idle PS2_CLK -> no FSM activity and no outputs.
- With key_up held, pull CPU_RESETN low in the middle of a frame -> all outputs 0 immediately. After release, a full E0,74 frame sets key_right=1.
